// File: rtl/add_result_buffer.sv
// rtl/add_result_buffer.sv - two-entry elastic buffer for adder result words
//
// Captures each adder result (sum with carry-out in its top bit, carry flag,
// signed-overflow flag) and forwards it through a 2-deep valid/ready buffer.
// Results are kept in FIFO order, and no result is lost while the consumer
// stalls.
//
// Optional feature macro: ADD_RESULT_STATS_EN
//   defined   : saturating carry/overflow event counters and a sticky overflow flag
//   undefined : carry_cnt, ovf_cnt and ovf_seen are tied to 0 and clr_stats is ignored
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   in_valid / in_ready      input handshake (in_ready is registered)
//   in_s, in_c, in_o         input payload: sum[W:0], carry, overflow
//   out_valid / out_ready    output handshake
//   out_s, out_c, out_o      head-of-buffer payload
//   clr_stats                synchronous clear of counters and sticky flag
//   carry_cnt, ovf_cnt       saturating counts of accepted beats with c / o set
//   ovf_seen                 sticky: some accepted beat had o set
module add_result_buffer #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W:0]       in_s,
    input  logic             in_c,
    input  logic             in_o,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W:0]       out_s,
    output logic             out_c,
    output logic             out_o,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] carry_cnt,
    output logic [CNT_W-1:0] ovf_cnt,
    output logic             ovf_seen
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic         in_ready_q;
    logic [W:0]   head_s, tail_s;
    logic         head_c, tail_c;
    logic         head_o, tail_o;
    logic         push, pop;
    logic         load_head, load_tail, shift;

    assign in_ready  = in_ready_q;
    assign out_valid = (state != EMPTY);
    assign out_s     = head_s;
    assign out_c     = head_c;
    assign out_o     = head_o;

    assign push = in_valid & in_ready_q;
    assign pop  = out_valid & out_ready;

    // The head entry always drives the outputs, so a stalled result remains stable.
    // An incoming beat goes to the head when the head becomes free this cycle.
    // Otherwise, it goes to the tail.
    always_comb begin
        state_nxt = state;
        load_head = 1'b0;
        load_tail = 1'b0;
        shift     = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt = ONE;
                    load_head = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_head = 1'b1;
                end else if (push) begin
                    state_nxt = FULL;
                    load_tail = 1'b1;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_nxt = ONE;
                    shift     = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
            head_s     <= '0;
            head_c     <= 1'b0;
            head_o     <= 1'b0;
            tail_s     <= '0;
            tail_c     <= 1'b0;
            tail_o     <= 1'b0;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != FULL);
            if (load_head) begin
                head_s <= in_s;
                head_c <= in_c;
                head_o <= in_o;
            end else if (shift) begin
                head_s <= tail_s;
                head_c <= tail_c;
                head_o <= tail_o;
            end
            if (load_tail) begin
                tail_s <= in_s;
                tail_c <= in_c;
                tail_o <= in_o;
            end
        end
    end

`ifdef ADD_RESULT_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] carry_cnt_q, ovf_cnt_q;
    logic             ovf_seen_q;

    assign carry_cnt = carry_cnt_q;
    assign ovf_cnt   = ovf_cnt_q;
    assign ovf_seen  = ovf_seen_q;

    // Events are counted when a beat is accepted, and clearing takes priority over counting.
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            carry_cnt_q <= '0;
            ovf_cnt_q   <= '0;
            ovf_seen_q  <= 1'b0;
        end else if (push) begin
            if (in_c && carry_cnt_q != CNT_MAX) carry_cnt_q <= carry_cnt_q + 1'b1;
            if (in_o && ovf_cnt_q != CNT_MAX)   ovf_cnt_q   <= ovf_cnt_q + 1'b1;
            if (in_o)                           ovf_seen_q  <= 1'b1;
        end
    end
`else
    logic unused_clr_stats;
    assign unused_clr_stats = clr_stats;
    assign carry_cnt = '0;
    assign ovf_cnt   = '0;
    assign ovf_seen  = 1'b0;
`endif

endmodule
